// File: rtl/ice51_uart_loader_pkg.sv
// ice51_uart_pkg: shared state encodings and bit-timing default for the ice51 UART receive path
package ice51_uart_pkg;
  localparam int CLKS_PER_BIT_DEF = 104;
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;
  localparam logic [1:0] LD_LOAD  = 2'd0;
  localparam logic [1:0] LD_CSUM  = 2'd1;
  localparam logic [1:0] LD_RUN   = 2'd2;
endpackage

// File: rtl/ice51_uart_loader_if.sv
// ice51_uart_loader_if: program-memory write port and CPU serial byte port of the loader
interface ice51_uart_loader_if #(parameter int ADDR_W = 10);
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [7:0]        o_mem_wdata;
  logic              o_cpu_run;
  logic              o_rx_valid;
  logic [7:0]        o_rx_data;
  logic              o_frame_err;
  logic              o_load_err;
  modport master (output o_mem_we, o_mem_addr, o_mem_wdata, o_cpu_run, o_rx_valid, o_rx_data, o_frame_err, o_load_err);
  modport slave  (input  o_mem_we, o_mem_addr, o_mem_wdata, o_cpu_run, o_rx_valid, o_rx_data, o_frame_err, o_load_err);
endinterface

// File: rtl/ice51_uart_loader_rx.sv
// ice51_uart_rx: 2-flop synchroniser plus 8N1 LSB-first deserialiser with glitch and framing checks
module ice51_uart_rx
  import ice51_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_frame_err
);
  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
  logic [1:0]    sync_q;
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shr_q, shr_d;
  logic          valid_q, valid_d, ferr_q, ferr_d;
  logic          rx;
  assign rx = sync_q[1];
  // Next-state: start-bit midpoint found in START, then every full bit period thereafter
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + 1'b1;
    bit_d   = bit_q;
    shr_d   = shr_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        tmr_d   = '0;
        state_d = rx ? RX_IDLE : RX_START;
      end
      RX_START: if (tmr_q == HALF) begin
        tmr_d   = '0;
        bit_d   = '0;
        state_d = rx ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (tmr_q == FULL) begin
        tmr_d   = '0;
        shr_d   = {rx, shr_q[7:1]};
        bit_d   = bit_q + 1'b1;
        state_d = (bit_q == 3'd7) ? RX_STOP : RX_DATA;
      end
      default: if (tmr_q == FULL) begin
        state_d = RX_IDLE;
        valid_d = rx;
        ferr_d  = !rx;
      end
    endcase
  end
  // State registers; synchroniser resets to the idle-high line level
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q  <= 2'b11;
      state_q <= RX_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      shr_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], i_rx};
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      shr_q   <= shr_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end
  assign o_byte_valid = valid_q;
  assign o_byte       = shr_q;
  assign o_frame_err  = ferr_q;
endmodule

// File: rtl/ice51_uart_loader.sv
// ice51_uart_loader: boot loader writing MEM_SIZE UART bytes to program memory, then forwarding bytes to the CPU; ICE51_LOADER_CSUM_EN adds a trailing checksum byte
module ice51_uart_loader
  import ice51_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int MEM_SIZE     = 1024,
  parameter int ADDR_W       = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_uart_rx,
  ice51_uart_loader_if.master bus
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_SIZE - 1);
`ifdef ICE51_LOADER_CSUM_EN
  localparam logic [1:0] LD_DONE = LD_CSUM;
`else
  localparam logic [1:0] LD_DONE = LD_RUN;
`endif
  logic              bv, ferr;
  logic [7:0]        rx_byte;
  logic [1:0]        st_q, st_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d, rxd_q, rxd_d;
  logic              we_q, we_d, rxv_q, rxv_d, run_q, ferr_q;
`ifdef ICE51_LOADER_CSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              lerr_q, lerr_d;
`endif
  ice51_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rx         (i_uart_rx),
    .o_byte_valid (bv),
    .o_byte       (rx_byte),
    .o_frame_err  (ferr)
  );
  // Loader next-state: memory writes during LOAD, optional checksum verdict, CPU forwarding in RUN
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    rxv_d   = 1'b0;
    rxd_d   = rxd_q;
`ifdef ICE51_LOADER_CSUM_EN
    sum_d   = sum_q;
    lerr_d  = lerr_q;
`endif
    if (bv) begin
      case (st_q)
        LD_LOAD: begin
          we_d    = 1'b1;
          addr_d  = cnt_q;
          wdata_d = rx_byte;
          cnt_d   = cnt_q + 1'b1;
          st_d    = (cnt_q == LAST) ? LD_DONE : LD_LOAD;
`ifdef ICE51_LOADER_CSUM_EN
          sum_d   = sum_q + rx_byte;
`endif
        end
`ifdef ICE51_LOADER_CSUM_EN
        LD_CSUM: begin
          st_d   = (8'(sum_q + rx_byte) == 8'h00) ? LD_RUN : LD_LOAD;
          lerr_d = lerr_q | (8'(sum_q + rx_byte) != 8'h00);
          cnt_d  = '0;
          sum_d  = '0;
        end
`endif
        LD_RUN: begin
          rxv_d = 1'b1;
          rxd_d = rx_byte;
        end
        default: st_d = LD_LOAD;
      endcase
    end
  end
  // Loader registers; cpu_run follows the RUN state one clock later
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st_q    <= LD_LOAD;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rxv_q   <= 1'b0;
      rxd_q   <= '0;
      run_q   <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef ICE51_LOADER_CSUM_EN
      sum_q   <= '0;
      lerr_q  <= 1'b0;
`endif
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rxv_q   <= rxv_d;
      rxd_q   <= rxd_d;
      run_q   <= (st_q == LD_RUN);
      ferr_q  <= ferr;
`ifdef ICE51_LOADER_CSUM_EN
      sum_q   <= sum_d;
      lerr_q  <= lerr_d;
`endif
    end
  end
  assign bus.o_mem_we    = we_q;
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_cpu_run   = run_q;
  assign bus.o_rx_valid  = rxv_q;
  assign bus.o_rx_data   = rxd_q;
  assign bus.o_frame_err = ferr_q;
`ifdef ICE51_LOADER_CSUM_EN
  assign bus.o_load_err  = lerr_q;
`else
  assign bus.o_load_err  = 1'b0;
`endif
endmodule

// File: tb/tb_ice51_uart_loader.sv
// tb_ice51_uart_loader: randomized UART frames checked against a byte-level loader model
module tb_ice51_uart_loader;
  localparam int CPB = 16;
  localparam int MEM = 4;
  localparam int AW  = 4;
`ifdef ICE51_LOADER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx  = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  ice51_uart_loader_if #(.ADDR_W(AW)) bus();
  ice51_uart_loader #(.CLKS_PER_BIT(CPB), .MEM_SIZE(MEM), .ADDR_W(AW)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_uart_rx (rx),
    .bus       (bus)
  );
  logic [15:0] got_w[$], exp_w[$];
  logic [7:0]  got_r[$], exp_r[$];
  int got_fe = 0, exp_fe = 0, viol = 0, cyc = 0, last_we = -1, rise = -1;
  logic prev_run = 1'b0;
  int m_cnt = 0;
  bit m_run = 1'b0, m_err = 1'b0;
  logic [7:0] m_sum = 8'h00;
  always @(negedge clk) begin
    cyc++;
    if (bus.o_mem_we) begin
      got_w.push_back(16'({bus.o_mem_addr, bus.o_mem_wdata}));
      last_we = cyc;
    end
    if (bus.o_rx_valid) got_r.push_back(bus.o_rx_data);
    if (bus.o_frame_err) got_fe++;
    if (bus.o_cpu_run && !prev_run) rise = cyc;
    if ((bus.o_mem_we && bus.o_cpu_run) || (bus.o_rx_valid && !bus.o_cpu_run)) viol++;
    prev_run = bus.o_cpu_run;
  end
  function automatic bit w_ok();
    if (got_w.size() != exp_w.size()) return 1'b0;
    foreach (got_w[i]) if (got_w[i] !== exp_w[i]) return 1'b0;
    return 1'b1;
  endfunction
  function automatic bit r_ok();
    if (got_r.size() != exp_r.size()) return 1'b0;
    foreach (got_r[i]) if (got_r[i] !== exp_r[i]) return 1'b0;
    return 1'b1;
  endfunction
  task automatic do_reset();
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    got_w.delete(); exp_w.delete(); got_r.delete(); exp_r.delete();
    got_fe = 0; exp_fe = 0; last_we = -1; rise = -1;
    m_cnt = 0; m_run = 1'b0; m_err = 1'b0; m_sum = 8'h00;
  endtask
  task automatic send(input logic [7:0] b, input bit good, input int gap);
    logic [9:0] f;
    f = {good, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      #1 rx = f[i];
      repeat (CPB) @(posedge clk);
    end
    #1 rx = 1'b1;
    repeat (gap) @(posedge clk);
    if (!good) exp_fe++;
    else if (m_run) exp_r.push_back(b);
    else if (m_cnt < MEM) begin
      exp_w.push_back(16'(m_cnt * 256 + b));
      m_sum += b;
      m_cnt++;
      if (!CSUM && m_cnt == MEM) m_run = 1'b1;
    end else if (8'(m_sum + b) == 8'h00) m_run = 1'b1;
    else begin
      m_err = 1'b1; m_cnt = 0; m_sum = 8'h00;
    end
  endtask
  task automatic send_csum(input int gap);
    if (CSUM) send(8'(256 - m_sum), 1'b1, gap);
  endtask
  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata, bus.o_cpu_run, bus.o_rx_valid, bus.o_rx_data, bus.o_frame_err, bus.o_load_err} !== '0) begin
      failures++; $display("FAIL reset outputs: got we=%b addr=%h wd=%h run=%b rv=%b rd=%h fe=%b le=%b want all 0",
        bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata, bus.o_cpu_run, bus.o_rx_valid, bus.o_rx_data, bus.o_frame_err, bus.o_load_err);
    end
    do_reset();
    repeat (3 * CPB) @(posedge clk);
    checks++;
    if (bus.o_cpu_run !== 1'b0 || got_w.size() != 0) begin
      failures++; $display("FAIL reset idle: run=%b writes=%0d want 0/0", bus.o_cpu_run, got_w.size());
    end
  endtask
  task automatic test_load();
    logic [7:0] d[4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    do_reset();
    foreach (d[i]) send(d[i], 1'b1, CPB);
    send_csum(CPB);
    repeat (CPB) @(posedge clk);
    checks++;
    if (!w_ok() || got_w.size() != 4 || got_w[3] !== 16'h0378) begin
      failures++; $display("FAIL load writes: got %0d writes last=%h want 4 ending 0378", got_w.size(), got_w.size() ? got_w[$] : 16'hxxxx);
    end
    checks++;
    if (bus.o_cpu_run !== 1'b1) begin failures++; $display("FAIL load cpu_run: got %b want 1", bus.o_cpu_run); end
`ifndef ICE51_LOADER_CSUM_EN
    checks++;
    if (rise - last_we != 1) begin failures++; $display("FAIL load run latency: got %0d want 1", rise - last_we); end
`endif
  endtask
  task automatic test_run();
    send(8'hA5, 1'b1, CPB);
    for (int i = 0; i < 6; i++) send(8'($urandom), ($urandom_range(0, 4) != 0), $urandom_range(0, CPB));
    repeat (CPB) @(posedge clk);
    checks++;
    if (!r_ok() || got_r.size() == 0 || got_r[0] !== 8'hA5) begin
      failures++; $display("FAIL run rx bytes: got %0d first=%h want %0d first=a5", got_r.size(), got_r.size() ? got_r[0] : 8'hxx, exp_r.size());
    end
    checks++;
    if (got_fe != exp_fe || !w_ok()) begin
      failures++; $display("FAIL run side effects: fe=%0d writes=%0d want fe=%0d writes=%0d", got_fe, got_w.size(), exp_fe, exp_w.size());
    end
  endtask
  task automatic test_glitch();
    #1 rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    checks++;
    if (got_r.size() != exp_r.size() || got_fe != exp_fe) begin
      failures++; $display("FAIL glitch: rx=%0d fe=%0d want rx=%0d fe=%0d", got_r.size(), got_fe, exp_r.size(), exp_fe);
    end
    send(8'h3C, 1'b1, CPB);
    checks++;
    if (!r_ok()) begin failures++; $display("FAIL glitch recovery: got %0d bytes want %0d", got_r.size(), exp_r.size()); end
  endtask
  task automatic test_frame_err();
    do_reset();
    send(8'h11, 1'b1, CPB);
    send(8'h22, 1'b0, CPB);
    send(8'h33, 1'b1, CPB);
    repeat (CPB) @(posedge clk);
    checks++;
    if (got_fe != 1) begin failures++; $display("FAIL frame_err pulses: got %0d want 1", got_fe); end
    checks++;
    if (!w_ok() || got_w.size() != 2 || got_w[1] !== 16'h0133) begin
      failures++; $display("FAIL frame_err address: got %0d writes last=%h want 2 ending 0133", got_w.size(), got_w.size() ? got_w[$] : 16'hxxxx);
    end
  endtask
  task automatic test_reset_midload();
    do_reset();
    send(8'hAA, 1'b1, CPB);
    send(8'hBB, 1'b1, CPB);
    do_reset();
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, CPB);
    send_csum(CPB);
    repeat (CPB) @(posedge clk);
    checks++;
    if (!w_ok() || got_w.size() != 4 || got_w[0] !== 16'h0001) begin
      failures++; $display("FAIL midload restart: got %0d writes first=%h want 4 starting 0001", got_w.size(), got_w.size() ? got_w[0] : 16'hxxxx);
    end
    checks++;
    if (bus.o_cpu_run !== 1'b1) begin failures++; $display("FAIL midload run: got %b want 1", bus.o_cpu_run); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < MEM; i++) send(8'($urandom), 1'b1, 0);
    send_csum(0);
    for (int i = 0; i < 4; i++) send(8'($urandom), 1'b1, 0);
    repeat (CPB) @(posedge clk);
    checks++;
    if (!w_ok() || !r_ok()) begin
      failures++; $display("FAIL back_to_back: writes %0d/%0d rx %0d/%0d (got/want)", got_w.size(), exp_w.size(), got_r.size(), exp_r.size());
    end
    checks++;
    if (bus.o_cpu_run !== m_run) begin failures++; $display("FAIL back_to_back run: got %b want %b", bus.o_cpu_run, m_run); end
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 14; i++) send(8'($urandom), ($urandom_range(0, 4) != 0), $urandom_range(0, 2 * CPB));
    repeat (CPB) @(posedge clk);
    checks++;
    if (!w_ok() || !r_ok() || got_fe != exp_fe) begin
      failures++; $display("FAIL random: writes %0d/%0d rx %0d/%0d fe %0d/%0d (got/want)", got_w.size(), exp_w.size(), got_r.size(), exp_r.size(), got_fe, exp_fe);
    end
    checks++;
    if (bus.o_cpu_run !== m_run || bus.o_load_err !== m_err) begin
      failures++; $display("FAIL random state: run=%b err=%b want run=%b err=%b", bus.o_cpu_run, bus.o_load_err, m_run, m_err);
    end
    checks++;
    if (viol != 0) begin failures++; $display("FAIL mode exclusivity: got %0d violations want 0", viol); end
  endtask
`ifdef ICE51_LOADER_CSUM_EN
  task automatic test_csum();
    do_reset();
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, CPB);
    send(8'hF6, 1'b1, CPB);
    repeat (CPB) @(posedge clk);
    checks++;
    if (bus.o_cpu_run !== 1'b1 || bus.o_load_err !== 1'b0) begin
      failures++; $display("FAIL csum good: run=%b err=%b want 1/0", bus.o_cpu_run, bus.o_load_err);
    end
    do_reset();
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, CPB);
    send(8'h00, 1'b1, CPB);
    repeat (CPB) @(posedge clk);
    checks++;
    if (bus.o_cpu_run !== 1'b0 || bus.o_load_err !== 1'b1) begin
      failures++; $display("FAIL csum bad: run=%b err=%b want 0/1", bus.o_cpu_run, bus.o_load_err);
    end
    send(8'h9E, 1'b1, CPB);
    repeat (CPB) @(posedge clk);
    checks++;
    if (!w_ok() || got_w[$] !== 16'h009E) begin
      failures++; $display("FAIL csum reload: last write %h want 009e", got_w[$]);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_load();
    test_run();
    test_glitch();
    test_frame_err();
    test_reset_midload();
    test_back_to_back();
`ifdef ICE51_LOADER_CSUM_EN
    test_csum();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
